// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence family (transmitter and detectors).
//   STATE_W / state_t  : FSM state register width and type
//   ST_*               : FSM state encodings (IDLE/SHIFT/GAP/DONE)
//   SEQ_DEFAULT_PAT    : pattern sent when a request carries an all-zero pattern
package seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [2:0] SEQ_DEFAULT_PAT = 3'b101;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern and repeat count over a
// valid/ready handshake and shifts it out MSB-first, repeated, with zero gap
// bits between repeats.
//   clk, reset        : clock (rising edge), async active-high reset
//   req_valid/ready   : request handshake; ready only in IDLE
//   pat_in, rep_in    : pattern (0 -> DEFAULT_PAT) and repeat count (0 -> 1)
//   tx_bit, tx_en     : serial data and pattern-bit qualifier
//   busy, done        : not-idle flag, one-cycle completion pulse
//   frame_cnt         : completed patterns since reset (wraps)
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned       PAT_W       = 3,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = PAT_W'(SEQ_DEFAULT_PAT),
    parameter int unsigned       GAP_CYCLES  = 1,
    parameter int unsigned       REP_W       = 4,
    parameter int unsigned       CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep_in,
    output logic             tx_bit,
    output logic             tx_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned BIT_W    = $clog2(PAT_W);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    state_t             state_q,  state_d;
    logic [PAT_W-1:0]   shift_q,  shift_d;
    logic [PAT_W-1:0]   pat_q,    pat_d;
    logic [BIT_W-1:0]   bit_q,    bit_d;
    logic [REP_W-1:0]   reps_q,   reps_d;
    logic [GAP_W-1:0]   gap_q,    gap_d;
    logic [CNT_W-1:0]   frame_d;
    logic               tx_bit_d, tx_en_d, busy_d, done_d, ready_d;

    // Next-state and next-output logic; outputs are decoded from the next
    // state so that the registered outputs line up with the registered state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        pat_d   = pat_q;
        bit_d   = bit_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        frame_d = frame_cnt;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    shift_d = (pat_in == '0) ? DEFAULT_PAT : pat_in;
                    pat_d   = (pat_in == '0) ? DEFAULT_PAT : pat_in;
                    reps_d  = (rep_in == '0) ? REP_W'(1) : rep_in;
                    bit_d   = BIT_LAST;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = {shift_q[PAT_W-2:0], 1'b0};
                bit_d   = bit_q - BIT_W'(1);
                if (bit_q == '0) begin
                    frame_d = frame_cnt + CNT_W'(1);
                    reps_d  = reps_q - REP_W'(1);
                    if (reps_q == REP_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        shift_d = pat_q;
                        bit_d   = BIT_LAST;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    shift_d = pat_q;
                    bit_d   = BIT_LAST;
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_en_d  = (state_d == ST_SHIFT);
        tx_bit_d = tx_en_d & shift_d[PAT_W-1];
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        ready_d  = (state_d == ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            pat_q     <= '0;
            bit_q     <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            frame_cnt <= '0;
            tx_bit    <= 1'b0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            pat_q     <= pat_d;
            bit_q     <= bit_d;
            reps_q    <= reps_d;
            gap_q     <= gap_d;
            frame_cnt <= frame_d;
            tx_bit    <= tx_bit_d;
            tx_en     <= tx_en_d;
            busy      <= busy_d;
            done      <= done_d;
            req_ready <= ready_d;
        end
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the driving end of the serial sequence-detector interface.
- Accepts a PAT_W-bit pattern plus a repeat count over a valid/ready request handshake.
- Shifts the pattern out MSB-first on a 1-bit serial line, repeated the requested number of times, with zero-filled gap bits between repeats.
- Drives detector-side stimulus and in-system link self-test; output feeds the `x` input of the team's Moore non-overlapping detectors.

Parameters:
- PAT_W, 3, pattern width in bits (min 2)
- DEFAULT_PAT, 3'b101, value transmitted when pat_in is all-zero
- GAP_CYCLES, 1, zero bits inserted between consecutive repeats (0 = back-to-back)
- REP_W, 4, width of repeat-count input
- CNT_W, 8, width of frame counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  1  request strobe
- req_ready  output  1  high when a request can be accepted
- pat_in  input  PAT_W  pattern to send; MSB transmitted first
- rep_in  input  REP_W  number of repeats; 0 treated as 1
- tx_bit  output  1  serial data
- tx_en  output  1  high while tx_bit carries a pattern bit
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last bit
- frame_cnt  output  CNT_W  completed patterns since reset; wraps

Behaviour:
- Clock is clk; reset is asynchronous, active-high. All state and counters are flopped.
- Moore FSM with states IDLE, SHIFT, GAP, DONE. All outputs decode from registered state and registers only; there is no combinational path from inputs to outputs.
- Reset values: state=IDLE, tx_bit=0, tx_en=0, busy=0, done=0, req_ready=1, frame_cnt=0, shift register=0, counters=0.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1: load shift_reg = (pat_in==0 ? DEFAULT_PAT : pat_in); load reps_left = (rep_in==0 ? 1 : rep_in); set bit_cnt=PAT_W-1; latch the pattern for reloads; go to SHIFT.
- SHIFT:
  - tx_en=1, tx_bit=shift_reg[MSB].
  - Each edge: shift left with zero fill and decrement bit_cnt.
  - At bit_cnt==0: frame_cnt++ and reps_left--.
  - If reps_left was 1, go to DONE. Otherwise go to GAP (GAP_CYCLES>0), or reload shift_reg and bit_cnt and stay in SHIFT (GAP_CYCLES==0).
- GAP:
  - tx_en=0, tx_bit=0.
  - Hold for exactly GAP_CYCLES cycles using gap_cnt, then reload shift_reg and bit_cnt and go to SHIFT.
- DONE: done=1 and busy=1 for one cycle, then unconditionally go to IDLE. tx_en=0, tx_bit=0.
- Latency:
  - The first bit is on tx_bit in the cycle immediately after the accepting edge.
  - A request for R repeats occupies R*PAT_W + (R-1)*GAP_CYCLES tx cycles, followed by 1 done cycle.
  - A new request can be accepted on the edge at which DONE returns to IDLE + 1 (the first IDLE cycle).
- Handshake:
  - req_ready = (state==IDLE).
  - req_valid is ignored while busy; no queuing.
  - pat_in and rep_in are sampled only at acceptance; later changes have no effect.
- tx_bit is 0 whenever tx_en=0.
- frame_cnt wraps from 2^CNT_W-1 to 0 silently.
- Reset mid-operation: all outputs return immediately to their reset values. done is not pulsed and the partial frame is not counted.
- rep_in all-ones (15) is legal and yields 15 repeats.

Decomposition:
- Shared package seq_pkg: state encoding typedef (IDLE/SHIFT/GAP/DONE) and the DEFAULT_PAT constant, which is shared with the detector family.
- Single module; no sub-module is natural.
- The bench instantiates the existing Moore non-overlapping detector as a loopback checker on tx_bit.

Test Plan:
- Reset, then pat_in=3'b101, rep_in=1, one-cycle req_valid -> tx_bit 1,0,1 with tx_en=1 on the three cycles after acceptance; done pulses in cycle 4; frame_cnt=1; req_ready high again in cycle 5.
- pat_in=3'b101, rep_in=3, GAP_CYCLES=1 -> tx_bit stream 1,0,1,0,1,0,1,0,1,0,1 over 11 cycles with tx_en low on gap cycles 4 and 8; frame_cnt=3; the loopback detector asserts detect exactly 3 times.
- rep_in=0 with pat_in=0 -> treated as 1 repeat of DEFAULT_PAT (1,0,1); frame_cnt=1.
- Second req_valid with pat_in=3'b111 asserted during SHIFT -> ignored; only the original pattern is sent; req_ready stays 0 until IDLE.
- reset asserted on the second bit of a rep_in=2 transfer -> next cycle tx_en=0, busy=0, frame_cnt=0, done never pulses; a fresh request afterwards transmits normally.
- 256 single-repeat requests -> frame_cnt wraps to 0 after the 256th done.
